mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory access latency in cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c_req  input  1  core request, held high until c_ack.
REQ-005 c_we  input  1  core write enable: 1 = write, 0 = read.
REQ-006 c_addr  input  32  core byte address.
REQ-007 c_wdata  input  32  core write data.
REQ-008 c_rdata  output  32  core read data, registered.
REQ-009 c_ack  output  1  core completion, one-cycle pulse.
REQ-010 l_req, l_we, l_addr[31:0], l_wdata[31:0]  input  loader port, same meaning as core port.
REQ-011 l_rdata  output  32 and l_ack  output  1  loader equivalents of c_rdata and c_ack.
REQ-012 m_addr  output  32  memory address.
REQ-013 m_wdata  output  32  memory write data.
REQ-014 m_read  output  1  memory read strobe.
REQ-015 m_write  output  1  memory write strobe.
REQ-016 m_rdata  input  32  memory read data, valid in the final ACCESS cycle.
REQ-017 grant  output  2  one-hot owner: bit0 core, bit1 loader; 00 when idle.
REQ-018 busy  output  1  high in ACCESS and DONE.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-020 IDLE with no request: remain IDLE.
REQ-021 IDLE with any request: select a winner, latch its we/addr/wdata, load counter with LAT-1, go to ACCESS next cycle.
REQ-022 Arbitration: single request wins outright; on simultaneous requests the port not granted last wins (round-robin).
REQ-023 ACCESS: m_addr and m_wdata driven from latched values.
REQ-024 ACCESS: m_read = !latched_we and m_write = latched_we, held constant for exactly LAT cycles.
REQ-025 ACCESS: counter decrements each cycle; at counter 0 go to DONE.
REQ-026 At counter 0 on a read, capture m_rdata into the winner's rdata register.
REQ-027 DONE: winner's ack high for exactly one cycle; last-granted updated to winner; next state IDLE.
REQ-028 Requests SHALL NOT be sampled during ACCESS or DONE.
REQ-029 Latency: ack asserted exactly LAT+1 cycles after the IDLE cycle that sampled the request.
REQ-030 Back-to-back throughput: one access per LAT+2 cycles.
REQ-031 Requester drops req in the ack cycle; a request still high in the following IDLE cycle is a new access.
REQ-032 rdata registers hold their value until the next completed read for that port; writes leave both unchanged.
REQ-033 Changes to the owner's inputs during ACCESS SHALL NOT affect m_addr, m_wdata, m_read or m_write.
REQ-034 A request arriving during another port's access waits and is granted in the next IDLE cycle.
REQ-035 Outside ACCESS: m_read = m_write = 0; m_addr and m_wdata hold their last latched values.
REQ-036 grant SHALL be one-hot for the owner throughout ACCESS and DONE.
REQ-037 c_ack and l_ack SHALL never be high in the same cycle.

Reset
REQ-038 With reset high at a clock edge, the next state SHALL be IDLE.
REQ-039 Reset SHALL clear counter, latched we/addr/wdata, c_rdata, l_rdata, m_addr and m_wdata to 0.
REQ-040 Reset SHALL clear c_ack, l_ack, m_read, m_write, grant and busy to 0.
REQ-041 Reset SHALL set last-granted to loader, so core wins the first tie.
REQ-042 Reset during ACCESS or DONE aborts the access: no ack issued, rdata not updated, strobes low the next cycle.

Verification
REQ-043 LAT=2, core read addr 0x10, memory returns 0xDEADBEEF -> m_read high 2 cycles; c_ack on cycle 3 after sampling; c_rdata=0xDEADBEEF.
REQ-044 Both req high after reset -> core served first; loader served next, ack 4 cycles later; repeat tie -> core.
REQ-045 Loader write addr 0x40 data 0x12345678 -> m_write high LAT cycles with that addr/data; l_ack pulses; l_rdata unchanged.
REQ-046 Core changes c_addr mid-ACCESS -> m_addr stays 0x10 until DONE.
REQ-047 Reset asserted in 2nd ACCESS cycle -> no ack; strobes 0 next cycle; state IDLE; a later request completes normally.
REQ-048 LAT=1 -> m_read high 1 cycle; ack 2 cycles after sampling; continuous core requests -> ack every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (core/loader) arbiter in front of a single fixed-latency memory.
// Round-robin on ties; each access runs IDLE -> ACCESS (LAT cycles) -> DONE.
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ack,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        m_read_q, m_read_d;
  logic        m_write_q, m_write_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic        c_ack_q, c_ack_d;
  logic        l_ack_q, l_ack_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        win_loader;
  logic        sel_we;

  // last_q = 1 means the loader was granted last, so the core wins a tie.
  assign win_loader = l_req & (~c_req | ~last_q);
  assign sel_we     = win_loader ? l_we : c_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    c_ack_d   = 1'b0;
    l_ack_d   = 1'b0;
    grant_d   = grant_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (c_req | l_req) begin
          owner_d   = win_loader;
          we_d      = sel_we;
          addr_d    = win_loader ? l_addr : c_addr;
          wdata_d   = win_loader ? l_wdata : c_wdata;
          cnt_d     = CNT_INIT;
          m_read_d  = ~sel_we;
          m_write_d = sel_we;
          grant_d   = win_loader ? 2'b10 : 2'b01;
          busy_d    = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          c_ack_d   = ~owner_q;
          l_ack_d   = owner_q;
          if (!we_q) begin
            if (owner_q) l_rdata_d = m_rdata;
            else         c_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
        busy_d  = 1'b0;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      c_rdata_q <= 32'd0;
      l_rdata_q <= 32'd0;
      c_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
      c_ack_q   <= c_ack_d;
      l_ack_q   <= l_ack_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  assign c_rdata = c_rdata_q;
  assign l_rdata = l_rdata_q;
  assign c_ack   = c_ack_q;
  assign l_ack   = l_ack_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign grant   = grant_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LAT=2 and LAT=1) checked every cycle
// against a transaction-timeline model, plus directed literal scenarios.
module tb_mem_arbiter;

  localparam int NI = 2;

  logic        clk;
  logic        rst     [NI];
  logic        c_req   [NI];
  logic        c_we    [NI];
  logic [31:0] c_addr  [NI];
  logic [31:0] c_wdata [NI];
  logic        l_req   [NI];
  logic        l_we    [NI];
  logic [31:0] l_addr  [NI];
  logic [31:0] l_wdata [NI];
  logic [31:0] m_rdata [NI];
  logic [31:0] c_rdata [NI];
  logic [31:0] l_rdata [NI];
  logic        c_ack   [NI];
  logic        l_ack   [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic        m_read  [NI];
  logic        m_write [NI];
  logic [1:0]  grant   [NI];
  logic        busy    [NI];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.LAT(g == 0 ? 2 : 1)) dut (
      .clk(clk), .reset(rst[g]),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_rdata(c_rdata[g]), .c_ack(c_ack[g]),
      .l_req(l_req[g]), .l_we(l_we[g]), .l_addr(l_addr[g]), .l_wdata(l_wdata[g]),
      .l_rdata(l_rdata[g]), .l_ack(l_ack[g]),
      .m_addr(m_addr[g]), .m_wdata(m_wdata[g]), .m_read(m_read[g]), .m_write(m_write[g]),
      .m_rdata(m_rdata[g]), .grant(grant[g]), .busy(busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Model: one in-flight transaction per instance described by its start cycle;
  // every output follows from the offset of the current cycle from that start.
  bit          valid      [NI];
  bit          tx_busy    [NI];
  int          tx_start   [NI];
  bit          tx_port    [NI];
  bit          tx_we      [NI];
  bit          last_ldr   [NI];
  logic [31:0] h_addr     [NI];
  logic [31:0] h_wdata    [NI];
  logic [31:0] exp_c_rd   [NI];
  logic [31:0] exp_l_rd   [NI];

  function automatic void resetModel(input int i);
    tx_busy[i]  = 1'b0;
    last_ldr[i] = 1'b1;
    h_addr[i]   = 32'd0;
    h_wdata[i]  = 32'd0;
    exp_c_rd[i] = 32'd0;
    exp_l_rd[i] = 32'd0;
  endfunction

  function automatic void modelStep(input int i);
    int lat, d;
    logic e_rd, e_wr, e_busy, e_cack, e_lack, idle_now, pick_l;
    logic [1:0] e_grant;
    lat = (i == 0) ? 2 : 1;
    if (!valid[i]) begin
      if (rst[i] === 1'b1) begin
        resetModel(i);
        valid[i] = 1'b1;
      end
      return;
    end
    e_rd = 0; e_wr = 0; e_busy = 0; e_cack = 0; e_lack = 0; e_grant = 2'b00;
    d = cyc - tx_start[i];
    if (tx_busy[i]) begin
      e_grant = tx_port[i] ? 2'b10 : 2'b01;
      e_busy  = 1'b1;
      if (d >= 1 && d <= lat) begin
        e_rd = !tx_we[i];
        e_wr = tx_we[i];
      end else begin
        e_cack = !tx_port[i];
        e_lack = tx_port[i];
      end
    end
    checkOutput($sformatf("i%0d c%0d m_read", i, cyc), 32'(m_read[i]), 32'(e_rd));
    checkOutput($sformatf("i%0d c%0d m_write", i, cyc), 32'(m_write[i]), 32'(e_wr));
    checkOutput($sformatf("i%0d c%0d grant", i, cyc), 32'(grant[i]), 32'(e_grant));
    checkOutput($sformatf("i%0d c%0d busy", i, cyc), 32'(busy[i]), 32'(e_busy));
    checkOutput($sformatf("i%0d c%0d c_ack", i, cyc), 32'(c_ack[i]), 32'(e_cack));
    checkOutput($sformatf("i%0d c%0d l_ack", i, cyc), 32'(l_ack[i]), 32'(e_lack));
    checkOutput($sformatf("i%0d c%0d m_addr", i, cyc), m_addr[i], h_addr[i]);
    checkOutput($sformatf("i%0d c%0d m_wdata", i, cyc), m_wdata[i], h_wdata[i]);
    checkOutput($sformatf("i%0d c%0d c_rdata", i, cyc), c_rdata[i], exp_c_rd[i]);
    checkOutput($sformatf("i%0d c%0d l_rdata", i, cyc), l_rdata[i], exp_l_rd[i]);
    if (rst[i] === 1'b1) begin
      resetModel(i);
      return;
    end
    idle_now = !tx_busy[i];
    if (tx_busy[i]) begin
      if (d == lat && !tx_we[i]) begin
        if (tx_port[i]) exp_l_rd[i] = m_rdata[i];
        else            exp_c_rd[i] = m_rdata[i];
      end
      if (d == lat + 1) begin
        tx_busy[i]  = 1'b0;
        last_ldr[i] = tx_port[i];
      end
    end
    if (idle_now && (c_req[i] || l_req[i])) begin
      pick_l      = l_req[i] && (!c_req[i] || !last_ldr[i]);
      tx_port[i]  = pick_l;
      tx_we[i]    = pick_l ? l_we[i] : c_we[i];
      h_addr[i]   = pick_l ? l_addr[i] : c_addr[i];
      h_wdata[i]  = pick_l ? l_wdata[i] : c_wdata[i];
      tx_start[i] = cyc;
      tx_busy[i]  = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) modelStep(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAck(input int i, input bit loader, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((loader ? l_ack[i] : c_ack[i]) !== 1'b1) && n < 40);
    checkOutput(loader ? "wait l_ack" : "wait c_ack",
                32'(loader ? l_ack[i] : c_ack[i]), 32'd1);
  endtask

  // Random requester: drops req on its ack, otherwise raises or jitters inputs.
  task automatic applyStimulus(input int i);
    m_rdata[i] = $urandom;
    rst[i] = ($urandom_range(0, 149) == 0);
    if (c_ack[i]) c_req[i] = 1'b0;
    else if (!c_req[i] && $urandom_range(0, 2) == 0) begin
      c_req[i] = 1'b1; c_we[i] = 1'($urandom_range(0, 1));
      c_addr[i] = $urandom; c_wdata[i] = $urandom;
    end else if (c_req[i] && $urandom_range(0, 2) == 0) begin
      c_we[i] = 1'($urandom_range(0, 1)); c_addr[i] = $urandom; c_wdata[i] = $urandom;
    end
    if (l_ack[i]) l_req[i] = 1'b0;
    else if (!l_req[i] && $urandom_range(0, 2) == 0) begin
      l_req[i] = 1'b1; l_we[i] = 1'($urandom_range(0, 1));
      l_addr[i] = $urandom; l_wdata[i] = $urandom;
    end else if (l_req[i] && $urandom_range(0, 2) == 0) begin
      l_we[i] = 1'($urandom_range(0, 1)); l_addr[i] = $urandom; l_wdata[i] = $urandom;
    end
  endtask

  initial begin
    int n, acks, prev;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; c_req[i] = 0; c_we[i] = 0; c_addr[i] = 0; c_wdata[i] = 0;
      l_req[i] = 0; l_we[i] = 0; l_addr[i] = 0; l_wdata[i] = 0; m_rdata[i] = 0;
    end
    repeat (3) tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    checkOutput("reset grant", 32'(grant[0]), 32'd0);
    checkOutput("reset busy", 32'(busy[0]), 32'd0);
    checkOutput("reset m_addr", m_addr[0], 32'd0);
    checkOutput("reset c_rdata", c_rdata[0], 32'd0);

    // Core read of 0x10 with the address changed mid-access.
    m_rdata[0] = 32'hDEADBEEF;
    c_req[0] = 1; c_we[0] = 0; c_addr[0] = 32'h10;
    tick();
    checkOutput("rd m_read c1", 32'(m_read[0]), 32'd1);
    checkOutput("rd m_addr c1", m_addr[0], 32'h10);
    checkOutput("rd grant c1", 32'(grant[0]), 32'd1);
    c_addr[0] = 32'h99;
    tick();
    checkOutput("rd m_read c2", 32'(m_read[0]), 32'd1);
    checkOutput("rd m_addr c2", m_addr[0], 32'h10);
    tick();
    checkOutput("rd c_ack c3", 32'(c_ack[0]), 32'd1);
    checkOutput("rd c_rdata c3", c_rdata[0], 32'hDEADBEEF);
    checkOutput("rd m_read c3", 32'(m_read[0]), 32'd0);
    checkOutput("rd m_addr c3", m_addr[0], 32'h10);
    c_req[0] = 0;
    tick();
    checkOutput("rd c_ack c4", 32'(c_ack[0]), 32'd0);

    // Tie after reset: core, then loader, then core again.
    rst[0] = 1;
    tick();
    rst[0] = 0;
    c_req[0] = 1; c_we[0] = 0; c_addr[0] = 32'h20;
    l_req[0] = 1; l_we[0] = 0; l_addr[0] = 32'h24;
    tick();
    checkOutput("tie1 grant", 32'(grant[0]), 32'd1);
    waitAck(0, 1'b0, n);
    c_req[0] = 0;
    waitAck(0, 1'b1, n);
    checkOutput("loader ack gap", 32'(n), 32'd4);
    c_req[0] = 1;
    tick();
    tick();
    checkOutput("tie2 grant", 32'(grant[0]), 32'd1);
    waitAck(0, 1'b0, n);
    c_req[0] = 0;
    waitAck(0, 1'b1, n);
    l_req[0] = 0;
    tick();
    tick();

    // Loader write leaves l_rdata alone.
    l_req[0] = 1; l_we[0] = 1; l_addr[0] = 32'h40; l_wdata[0] = 32'h12345678;
    tick();
    checkOutput("wr m_write c1", 32'(m_write[0]), 32'd1);
    checkOutput("wr m_read c1", 32'(m_read[0]), 32'd0);
    checkOutput("wr m_addr c1", m_addr[0], 32'h40);
    checkOutput("wr m_wdata c1", m_wdata[0], 32'h12345678);
    checkOutput("wr grant c1", 32'(grant[0]), 32'd2);
    tick();
    checkOutput("wr m_write c2", 32'(m_write[0]), 32'd1);
    tick();
    checkOutput("wr l_ack c3", 32'(l_ack[0]), 32'd1);
    checkOutput("wr m_write c3", 32'(m_write[0]), 32'd0);
    checkOutput("wr l_rdata c3", l_rdata[0], 32'hDEADBEEF);
    l_req[0] = 0;
    tick();

    // Reset during the second ACCESS cycle aborts; the held request then completes.
    c_req[0] = 1; c_we[0] = 0; c_addr[0] = 32'h80;
    tick();
    tick();
    rst[0] = 1;
    tick();
    checkOutput("abort c_ack", 32'(c_ack[0]), 32'd0);
    checkOutput("abort m_read", 32'(m_read[0]), 32'd0);
    checkOutput("abort busy", 32'(busy[0]), 32'd0);
    checkOutput("abort grant", 32'(grant[0]), 32'd0);
    rst[0] = 0;
    waitAck(0, 1'b0, n);
    checkOutput("after abort latency", 32'(n), 32'd3);
    c_req[0] = 0;
    tick();

    // LAT=1 with a continuously held core request.
    m_rdata[1] = 32'hCAFEF00D;
    c_req[1] = 1; c_we[1] = 0; c_addr[1] = 32'h10;
    acks = 0;
    prev = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 1) checkOutput("lat1 m_read on", 32'(m_read[1]), 32'd1);
      if (t == 2) checkOutput("lat1 m_read off", 32'(m_read[1]), 32'd0);
      if (c_ack[1]) begin
        if (acks == 0) checkOutput("lat1 first ack", 32'(t), 32'd2);
        else           checkOutput("lat1 ack gap", 32'(t - prev), 32'd3);
        prev = t;
        acks++;
      end
    end
    checkOutput("lat1 ack count", 32'(acks), 32'd5);
    c_req[1] = 0;
    tick();
    checkOutput("lat1 c_rdata", c_rdata[1], 32'hCAFEF00D);

    for (int k = 0; k < 4000; k++) begin
      applyStimulus(0);
      applyStimulus(1);
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      rst[i] = 0; c_req[i] = 0; l_req[i] = 0;
    end
    repeat (10) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
